button_debounce: RTL
====================

// Module: button_debounce
// PURPOSE
//  Conditions one raw mechanical push-button (board KEY) into a clean, glitch-free level.
//  Sits directly upstream of ButtonSync: Bd drives ButtonSync.Bi, which turns each press into a 1-cycle pulse.
//  Synchronises the asynchronous pin, normalises its polarity, then requires the new level to be stable
//  for a programmable time before Bd follows it.
// PARAMETERS
//  CLK_HZ       50_000_000  Clock frequency in Hz.
//  DEBOUNCE_MS  10          Required stable time in ms; STABLE_CYCLES = (CLK_HZ/1000)*DEBOUNCE_MS.
//  ACTIVE_LOW   1           1: pin reads 0 when pressed (DE-series KEY); 0: pin reads 1 when pressed.
//  SYNC_STAGES  2           Synchroniser depth. Must be >= 2.
// PORTS
//  Clock       in   1      System clock; all state updates on posedge.
//  Reset       in   1      Synchronous, active-high reset.
//  Bi_raw      in   1      Raw asynchronous button pin.
//  Bd          out  1      Debounced level: 1 = pressed. Feeds ButtonSync.Bi.
//  GlitchCount out  8      Rejected-bounce counter. Present only with BUTTON_GLITCH_COUNT_EN.
// BEHAVIOUR
//  - Normalise: s_in = ACTIVE_LOW ? ~Bi_raw : Bi_raw. s_in passes through SYNC_STAGES flops to give s.
//    Synchroniser flops reset to 0 (released).
//  - FSM states: RELEASED, WAIT_PRESS, PRESSED, WAIT_RELEASE. Reset: RELEASED, cnt=0, Bd=0, GlitchCount=0.
//  - RELEASED: s=1 -> WAIT_PRESS with cnt=0.
//  - WAIT_PRESS:
//    . s=0 -> RELEASED (abort).
//    . s=1 and cnt==STABLE_CYCLES-1 -> PRESSED.
//    . otherwise cnt++.
//  - PRESSED / WAIT_RELEASE: mirror image of the above with s inverted.
//  - Bd is registered: 1 in PRESSED and WAIT_RELEASE, 0 in RELEASED and WAIT_PRESS.
//  - Latency: Bd changes exactly SYNC_STAGES + STABLE_CYCLES + 1 cycles after a clean raw edge.
//    Any reversion of s before that restarts the wait from the stable state.
//  - Bd never toggles more than once per qualified edge. No output pulses; edge detection belongs to ButtonSync.
//  - cnt width = $clog2(STABLE_CYCLES+1). cnt never wraps; it is cleared on every state entry.
//  - Reset mid-wait: next cycle is RELEASED with Bd=0, even if the button is still held.
//    The press then re-qualifies from scratch.
//  - Reset takes priority over every other event in the same cycle.
//  - STABLE_CYCLES < 1 or SYNC_STAGES < 2 is an elaboration-time $error.
// CONFIGURATION
//  - Macro BUTTON_GLITCH_COUNT_EN.
//  - Defined: GlitchCount port exists. It increments by 1 on each abort, i.e. each
//    WAIT_PRESS->RELEASED or WAIT_RELEASE->PRESSED transition. It saturates at 8'hFF and clears on Reset.
//  - Undefined: the port and the counter are absent. Bd behaviour is identical in both builds.
// STRUCTURE
//  - Shared package button_pkg holds:
//    . typedef enum logic [1:0] db_state_t {RELEASED, WAIT_PRESS, PRESSED, WAIT_RELEASE};
//    . function debounce_cycles(clk_hz, ms);
//    . localparam GLITCH_W = 8.
//  - Sub-module bit_synchronizer (parameter STAGES, synchronous reset to 0) implements the sync chain.
//    It is reusable for other board inputs.
//  - FSM plus counter stay in this module.
// TESTING (CLK_HZ=1000, DEBOUNCE_MS=4 -> STABLE_CYCLES=4, SYNC_STAGES=2, ACTIVE_LOW=1)
//  1. Reset held 3 cycles with Bi_raw=1.
//     -> Bd=0 and GlitchCount=0 during reset and after release.
//  2. Bi_raw 1->0, then held 20 cycles.
//     -> Bd rises exactly 7 cycles after the raw edge and stays 1.
//  3. Press bounce: Bi_raw low 2 cycles / high 2 cycles repeated 3 times, then low steady.
//     -> Bd stays 0 during the bounce and rises 7 cycles after the final falling edge.
//     -> GlitchCount counts the aborted qualifications and is >=2.
//  4. From pressed, release with the mirror bounce, then Bi_raw=1 steady.
//     -> Bd falls 7 cycles after the final rising edge, with no intermediate toggle.
//  5. Reset asserted 1 cycle while in WAIT_PRESS, with Bi_raw still 0.
//     -> Bd=0 next cycle; Bd re-rises 7 cycles after Reset deasserts.
//  6. Bd connected to ButtonSync.Bi; 5 bouncy presses applied.
//     -> exactly 5 Bo pulses, each 1 cycle wide.
//  Also: with BUTTON_GLITCH_COUNT_EN, force 300 aborts -> GlitchCount holds at 8'hFF.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button conditioning path.
package button_pkg;

    localparam int GLITCH_W = 8;

    typedef enum logic [1:0] {
        RELEASED,
        WAIT_PRESS,
        PRESSED,
        WAIT_RELEASE
    } db_state_t;

    function automatic int debounce_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for one asynchronous input bit; clears to 0 on reset.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: sync + polarity normalise + stable-time qualification.
// Optional rejected-bounce counter on GlitchCount when BUTTON_GLITCH_COUNT_EN is defined.
module button_debounce
    import button_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 10,
    parameter int ACTIVE_LOW  = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Bi_raw,
`ifdef BUTTON_GLITCH_COUNT_EN
    output logic [GLITCH_W-1:0] GlitchCount,
`endif
    output logic                Bd
);

    localparam int STABLE_CYCLES = debounce_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int CNT_W         = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("button_debounce: STABLE_CYCLES must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("button_debounce: SYNC_STAGES must be >= 2");
    end

    logic      s_in;
    logic      s;
    db_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic      bd_q, bd_d;

    assign s_in = (ACTIVE_LOW != 0) ? ~Bi_raw : Bi_raw;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (Clock),
        .rst_i  (Reset),
        .d_i    (s_in),
        .q_o    (s)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            bd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bd_q    <= bd_d;
        end
    end

    // Counter is cleared on every state change so each wait starts from zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RELEASED: begin
                if (s) begin
                    state_d = WAIT_PRESS;
                    cnt_d   = '0;
                end
            end
            WAIT_PRESS: begin
                if (!s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = WAIT_RELEASE;
                    cnt_d   = '0;
                end
            end
            WAIT_RELEASE: begin
                if (s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        bd_d = (state_d == PRESSED) || (state_d == WAIT_RELEASE);
    end

    assign Bd = bd_q;

`ifdef BUTTON_GLITCH_COUNT_EN
    logic                abort;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;

    assign abort = ((state_q == WAIT_PRESS) && !s) || ((state_q == WAIT_RELEASE) && s);

    always_comb begin
        glitch_d = glitch_q;
        if (abort && (glitch_q != {GLITCH_W{1'b1}})) begin
            glitch_d = glitch_q + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign GlitchCount = glitch_q;
`endif

endmodule
